// File: rtl/result_memory_writer.sv
// Result memory writer: buffers result elements in a small FIFO and writes them sequentially to vector memory.
// Optional macro RESULT_RELU_EN clamps negative elements to zero on the write data path.
module result_memory_writer #(
   parameter int BASE_ADDR = 0,
   parameter int LENGTH    = 4,
   parameter int DEPTH     = 4
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        en,
   input  logic [15:0] result_element,
   input  logic        result_valid,
   input  logic        result_last,
   output logic        result_ready,
   input  logic        mem_grant,
   output logic [9:0]  vector_memory_address,
   output logic        memory_enable,
   output logic        memory_write,
   output logic [15:0] filter_write_element,
   output logic [9:0]  write_count,
   output logic        busy,
   output logic        done
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

   state_t            state_reg, state_next;
   logic [16:0]       fifo_mem [DEPTH];   // {last flag, element}
   logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
   logic [PTR_W:0]    fill_reg;
   logic [9:0]        accept_count_reg;
   logic [9:0]        write_count_reg;
   logic              final_accepted_reg;
   logic              mem_enable_reg;
   logic [9:0]        address_reg;
   logic [15:0]       data_reg;
   logic              done_reg;

   logic              fifo_full, fifo_empty;
   logic              push, pop, last_write;
   logic [16:0]       head;
   logic [15:0]       write_data;

   assign fifo_full  = (fill_reg == (PTR_W+1)'(DEPTH));
   assign fifo_empty = (fill_reg == '0);
   assign head       = fifo_mem[rd_ptr_reg];

   assign pop  = (state_reg == WRITE) && !fifo_empty && mem_grant && en;
   // A pop in the same edge frees a slot, so a full FIFO can still accept.
   assign result_ready = (state_reg == WRITE) && (!fifo_full || pop) && !final_accepted_reg;
   assign push = result_valid && result_ready;
   assign last_write = pop && ((write_count_reg == 10'(LENGTH - 1)) || head[16]);

`ifdef RESULT_RELU_EN
   assign write_data = head[15] ? 16'd0 : head[15:0];
`else
   assign write_data = head[15:0];
`endif

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (en) state_next = WRITE;
         WRITE: begin
            if (!en)             state_next = IDLE;
            else if (last_write) state_next = DONE;
         end
         DONE:    if (!en) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (push) fifo_mem[wr_ptr_reg] <= {result_last, result_element};
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_reg          <= IDLE;
         wr_ptr_reg         <= '0;
         rd_ptr_reg         <= '0;
         fill_reg           <= '0;
         accept_count_reg   <= '0;
         write_count_reg    <= '0;
         final_accepted_reg <= 1'b0;
         mem_enable_reg     <= 1'b0;
         address_reg        <= '0;
         data_reg           <= '0;
         done_reg           <= 1'b0;
      end else begin
         state_reg      <= state_next;
         mem_enable_reg <= pop;
         address_reg    <= pop ? 10'(BASE_ADDR) + write_count_reg : 10'd0;
         data_reg       <= pop ? write_data : 16'd0;
         done_reg       <= last_write;
         // Returning to IDLE (abort or end of run) flushes everything for a fresh run.
         if (state_next == IDLE) begin
            wr_ptr_reg         <= '0;
            rd_ptr_reg         <= '0;
            fill_reg           <= '0;
            accept_count_reg   <= '0;
            write_count_reg    <= '0;
            final_accepted_reg <= 1'b0;
         end else begin
            if (push) begin
               wr_ptr_reg       <= wr_ptr_reg + 1'b1;
               accept_count_reg <= accept_count_reg + 1'b1;
               if ((accept_count_reg == 10'(LENGTH - 1)) || result_last)
                  final_accepted_reg <= 1'b1;
            end
            if (pop) begin
               rd_ptr_reg      <= rd_ptr_reg + 1'b1;
               write_count_reg <= write_count_reg + 1'b1;
            end
            if (push && !pop)      fill_reg <= fill_reg + 1'b1;
            else if (pop && !push) fill_reg <= fill_reg - 1'b1;
         end
      end
   end

   assign vector_memory_address = address_reg;
   assign memory_enable         = mem_enable_reg;
   assign memory_write          = mem_enable_reg;
   assign filter_write_element  = data_reg;
   assign write_count           = write_count_reg;
   assign busy                  = (state_reg == WRITE);
   assign done                  = done_reg;

endmodule

// File: tb/tb_result_memory_writer.sv
// Randomized bench for result_memory_writer against a queue-based reference model.
module tb_result_memory_writer;

   localparam int BASE   = 10'h3FD;
   localparam int LENGTH = 7;
   localparam int DEPTH  = 4;

   logic        clock = 1'b0;
   logic        clear;
   logic        en;
   logic [15:0] result_element;
   logic        result_valid;
   logic        result_last;
   logic        result_ready;
   logic        mem_grant;
   logic [9:0]  vector_memory_address;
   logic        memory_enable;
   logic        memory_write;
   logic [15:0] filter_write_element;
   logic [9:0]  write_count;
   logic        busy;
   logic        done;

   result_memory_writer #(.BASE_ADDR(BASE), .LENGTH(LENGTH), .DEPTH(DEPTH)) dut (
      .clock                 (clock),
      .clear                 (clear),
      .en                    (en),
      .result_element        (result_element),
      .result_valid          (result_valid),
      .result_last           (result_last),
      .result_ready          (result_ready),
      .mem_grant             (mem_grant),
      .vector_memory_address (vector_memory_address),
      .memory_enable         (memory_enable),
      .memory_write          (memory_write),
      .filter_write_element  (filter_write_element),
      .write_count           (write_count),
      .busy                  (busy),
      .done                  (done)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [15:0] expected_data(input logic [15:0] d);
`ifdef RESULT_RELU_EN
      return ($signed(d) < 0) ? 16'd0 : d;
`else
      return d;
`endif
   endfunction

   // Reference model: phase (0 idle, 1 running, 2 finished), pending elements, counts.
   int          mst;
   int          acc;
   int          wr;
   bit          fin;
   logic [16:0] q[$];
   logic [16:0] hd;
   bit          pop_e, push_e, rdy_e;
   bit          exp_en, exp_done;
   logic [9:0]  exp_addr;
   logic [15:0] exp_data;

   initial begin
      int p_valid, p_grant, p_last, stall, abort_at, cyc, hold;
      bit run_end;

      clear = 1'b0; en = 1'b0; result_valid = 1'b0; result_last = 1'b0;
      result_element = '0; mem_grant = 1'b0;
      mst = 0; acc = 0; wr = 0; fin = 0;
      #12;
      check_value("rst_ready", result_ready, 0);
      check_value("rst_mem_en", memory_enable, 0);
      check_value("rst_mem_wr", memory_write, 0);
      check_value("rst_addr", vector_memory_address, 0);
      check_value("rst_data", filter_write_element, 0);
      check_value("rst_wcount", write_count, 0);
      check_value("rst_busy", busy, 0);
      check_value("rst_done", done, 0);
      @(negedge clock);
      clear = 1'b1;

      for (int run = 0; run < 40; run++) begin
         p_valid  = (run < 2) ? 100 : $urandom_range(40, 100);
         p_grant  = (run < 2) ? 100 : $urandom_range(30, 100);
         stall    = (run == 1) ? 10 : $urandom_range(0, 12);
         p_last   = (run % 3 == 2) ? 20 : 0;
         abort_at = (run % 4 == 3) ? $urandom_range(1, 15) : -1;
         cyc = 0; hold = 0; run_end = 0;
         while (!run_end) begin
            @(negedge clock);
            en = 1'b1;
            if (abort_at >= 0 && cyc == abort_at) en = 1'b0;
            if (mst == 2 && hold >= 1) en = 1'b0;
            result_valid   = ($urandom_range(0, 99) < p_valid);
            result_last    = ($urandom_range(0, 99) < p_last);
            result_element = 16'($urandom);
            mem_grant      = (cyc >= stall) && ($urandom_range(0, 99) < p_grant);
            #1;
            pop_e  = (mst == 1) && (q.size() > 0) && mem_grant && en;
            rdy_e  = (mst == 1) && ((q.size() < DEPTH) || pop_e) && !fin;
            check_value("ready", result_ready, rdy_e);
            push_e = result_valid && rdy_e;
            exp_en = 0; exp_done = 0; exp_addr = '0; exp_data = '0;
            case (mst)
               0: if (en) mst = 1;
               1: begin
                  if (!en) begin
                     mst = 0; q.delete(); acc = 0; wr = 0; fin = 0;
                  end else begin
                     if (pop_e) begin
                        hd = q.pop_front();
                        exp_en   = 1;
                        exp_addr = 10'((BASE + wr) % 1024);
                        exp_data = expected_data(hd[15:0]);
                        wr++;
                        if (wr == LENGTH || hd[16]) begin
                           exp_done = 1; mst = 2;
                        end
                     end
                     if (push_e) begin
                        q.push_back({result_last, result_element});
                        acc++;
                        if (acc == LENGTH || result_last) fin = 1;
                     end
                  end
               end
               default: if (!en) begin
                  mst = 0; acc = 0; wr = 0; fin = 0;
               end
            endcase
            @(posedge clock);
            #1;
            check_value("mem_en", memory_enable, exp_en);
            check_value("mem_wr", memory_write, exp_en);
            check_value("wdata", filter_write_element, exp_data);
            if (exp_en) check_value("addr", vector_memory_address, exp_addr);
            check_value("done", done, exp_done);
            check_value("wcount", write_count, wr);
            check_value("busy", busy, mst == 1);
            if (memory_enable || exp_en)
               $display("run %0d write addr=0x%03h data=0x%04h done=%0b count=%0d",
                        run, vector_memory_address, filter_write_element, done, write_count);
            if (!en) run_end = 1;
            if (mst == 2) hold++;
            cyc++;
            if (cyc > 400) begin
               check_value("timeout", 1, 0);
               run_end = 1;
            end
         end
      end

      // Asynchronous reset in the middle of a run.
      @(negedge clock);
      en = 1'b1; result_valid = 1'b1; result_last = 1'b0; mem_grant = 1'b0;
      repeat (3) @(negedge clock);
      #2;
      clear = 1'b0;
      #1;
      check_value("arst_busy", busy, 0);
      check_value("arst_ready", result_ready, 0);
      check_value("arst_wcount", write_count, 0);
      check_value("arst_mem_en", memory_enable, 0);
      en = 1'b0; result_valid = 1'b0;
      @(negedge clock);
      clear = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
